// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one data-memory port between the core load/store path (c_*) and an
//   auxiliary requester such as an I/O loader or DMA engine (a_*). Each access
//   is a two-phase transaction. In ISS_x the memory port is driven from the
//   granted requester's live inputs. In RSP_x the requester receives a
//   one-cycle ack and the memory read data.
//
//   Optional feature macro: WRITE_POST_EN
//     When defined, a write is acknowledged in its ISS cycle and the FSM
//     arbitrates straight from ISS, so back-to-back writes run one per cycle.
//     Reads are unchanged.
//
// Parameters
//   ADDR_W      address width (core, aux, memory)
//   DATA_W      data width
//   FIXED_PRIO  0 = round-robin between core and aux, 1 = core always wins
//
// Ports
//   clk                       rising-edge clock
//   reset                     asynchronous, active-low reset
//   c_req/c_we/c_addr/c_wdata core request, held until c_ack
//   c_rdata, c_ack, c_stall   core read data, completion pulse, stall
//   a_req/a_we/a_addr/a_wdata aux request, held until a_ack
//   a_rdata, a_ack            aux read data, completion pulse
//   m_en/m_we/m_addr/m_wdata  memory port command
//   m_rdata                   memory read data, one cycle after a read issue
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  output logic              c_stall,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISS_C = 3'd1,
    RSP_C = 3'd2,
    ISS_A = 3'd3,
    RSP_A = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;       // last requester served: 0 = core, 1 = aux
  logic   w_last_next;
  logic   w_arb;        // this cycle may start a new access
  logic   w_grant_c;
  logic   w_grant_a;

  // Grant decision. With FIXED_PRIO=0 a tie goes to whoever was not served
  // last, which bounds the wait of a requester to one access of the other.
  always_comb begin
    w_grant_c = 1'b0;
    w_grant_a = 1'b0;
    if (c_req && a_req) begin
      if ((FIXED_PRIO != 0) || r_last) w_grant_c = 1'b1;
      else                             w_grant_a = 1'b1;
    end else if (c_req) begin
      w_grant_c = 1'b1;
    end else if (a_req) begin
      w_grant_a = 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    w_arb       = 1'b0;
    m_en        = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    c_ack       = 1'b0;
    a_ack       = 1'b0;

    unique case (r_state)
      IDLE: w_arb = 1'b1;
      ISS_C: begin
        m_en    = 1'b1;
        m_we    = c_we;
        m_addr  = c_addr;
        m_wdata = c_wdata;
        w_next  = RSP_C;
`ifdef WRITE_POST_EN
        if (c_we) begin
          c_ack = 1'b1;
          w_arb = 1'b1;
        end
`endif
      end
      RSP_C: begin
        c_ack = 1'b1;
        w_arb = 1'b1;
      end
      ISS_A: begin
        m_en    = 1'b1;
        m_we    = a_we;
        m_addr  = a_addr;
        m_wdata = a_wdata;
        w_next  = RSP_A;
`ifdef WRITE_POST_EN
        if (a_we) begin
          a_ack = 1'b1;
          w_arb = 1'b1;
        end
`endif
      end
      RSP_A: begin
        a_ack = 1'b1;
        w_arb = 1'b1;
      end
      default: w_next = IDLE;
    endcase

    // The served flag moves together with the grant, so an ISS cycle that
    // arbitrates (posted write) already sees its own requester as last.
    if (w_arb) begin
      if (w_grant_c) begin
        w_next      = ISS_C;
        w_last_next = 1'b0;
      end else if (w_grant_a) begin
        w_next      = ISS_A;
        w_last_next = 1'b1;
      end else begin
        w_next      = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
    end
  end

  // Read data is a plain copy of the memory bus; it is only meaningful while
  // the matching ack is high.
  assign c_rdata = m_rdata;
  assign a_rdata = m_rdata;
  assign c_stall = c_req & ~c_ack;

endmodule
